data_memory: RTL and testbench
==============================

# data_memory

Word-addressed 256 x 32-bit data memory for the datapath's load/store stage. Writes are synchronous to the clock, gated by a write enable, and take effect at the rising edge. Reads are combinational from the current address. An asynchronous active-low reset clears the whole array to zero.

## Interface

Parameters:
- `DATA_WIDTH`, default 32: word width in bits.
- `ADDR_WIDTH`, default 8: address width in bits.
- `DEPTH`, default 2**ADDR_WIDTH (256): number of words; every address value maps to one word.

Ports (one clock; reset is asynchronous and active-low):
- `clk`  input  1: the single clock; all writes occur on its rising edge.
- `rst_n`  input  1: asynchronous active-low reset; clears every word to 0.
- `address`  input  ADDR_WIDTH: word address for both read and write; no byte offset.
- `write_data`  input  DATA_WIDTH: data written when `write_enable` = 1.
- `write_enable`  input  1: 1 writes at the next rising `clk`; 0 leaves the memory unchanged.
- `read_data`  output  DATA_WIDTH: contents of the word at `address`.

## Operation

- Storage is an array of DEPTH words, each DATA_WIDTH wide, held in flops so reset can clear it.
- Write:
  - Applies on the rising `clk` when `rst_n` = 1 and `write_enable` = 1.
  - Stores `write_data` into `mem[address]`; all other words hold.
- Read:
  - `read_data` = `mem[address]` combinationally at all times, regardless of `write_enable`.
- There is no read enable and no handshake; the block is always ready.
- Every 8-bit address is valid; 8'hFF is the last word. No wrap or out-of-range case exists at the default parameters.
- If DEPTH < 2**ADDR_WIDTH:
  - Writes to addresses >= DEPTH are ignored.
  - Reads from those addresses return 0.
- Reset:
  - `rst_n` = 0 asynchronously forces every word to 0, so `read_data` = 0 for any address.
  - A write attempted while `rst_n` = 0 is ignored.
  - Reset asserted mid-sequence discards all stored data.
- `X`/`Z` on `write_enable` must not corrupt the memory; treat anything other than 1 as no write.

## Timing

- Write latency is one edge: data presented before rising edge N is readable right after edge N.
- Read latency is zero, combinational from `address` and array state.
- Same address, write and read in the same cycle:
  - Before the edge, `read_data` shows the old contents. There is no write-through bypass.
  - After the edge, `read_data` shows the new data.
- Changing `address` with `write_enable` = 0 updates `read_data` within the same cycle.
- Reset:
  - Assertion takes effect immediately, without waiting for `clk`.
  - Deassertion is synchronized by the system; the first write is honoured on the first rising edge after `rst_n` goes high.
- Reset value of the only output: `read_data` = 32'h0000_0000.

## Test plan

1. Apply reset (`rst_n` = 0, then 1), sweep `address` over 00, 7F, FF -> `read_data` = 32'h00000000 each.
2. `address` = 00, `write_data` = 32'hAABBCCDD, `write_enable` = 1, one clock edge; then `write_enable` = 0, `address` = 00 -> `read_data` = 32'hAABBCCDD.
3. `write_enable` = 0, `address` = 00, `write_data` = 32'h12345678, several edges -> `read_data` remains 32'hAABBCCDD.
4. Write 32'h11111111 to 01 and 32'hFFFFFFFF to FF on consecutive edges; read 00, 01, FF -> AABBCCDD, 11111111, FFFFFFFF (no aliasing, top address works).
5. Same-cycle check: `address` = 01, `write_data` = 32'hCAFEF00D, `write_enable` = 1:
   - Before the edge, `read_data` = 32'h11111111.
   - After the edge, `read_data` = 32'hCAFEF00D.
6. Pull `rst_n` low between clock edges, with no `clk` edge, while `write_enable` = 1:
   - `read_data` at 01 drops to 0 immediately.
   - After release, address 00 also reads 0.

Source files
------------

// File: rtl/data_memory_if.sv
// Load/store port bundle for data_memory: one word address shared by read and write,
// with a write strobe and a combinational read return.
interface data_memory_if #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8
);
    logic [ADDR_WIDTH-1:0] address;
    logic [DATA_WIDTH-1:0] write_data;
    logic                  write_enable;
    logic [DATA_WIDTH-1:0] read_data;

    modport master (
        output address,
        output write_data,
        output write_enable,
        input  read_data
    );

    modport slave (
        input  address,
        input  write_data,
        input  write_enable,
        output read_data
    );
endinterface

// File: rtl/data_memory.sv
// Flop-based word-addressed data memory: synchronous write, combinational read,
// asynchronous active-low clear of the whole array.
module data_memory #(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 8,
    parameter int DEPTH      = 2**ADDR_WIDTH
) (
    input  logic         clk,
    input  logic         rst_n,
    data_memory_if.slave bus
);
    localparam logic [ADDR_WIDTH:0] LAST = (ADDR_WIDTH+1)'(DEPTH);

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic                  in_range;

    // Addresses past a short array are ignored on write and read back as zero.
    assign in_range = {1'b0, bus.address} < LAST;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
        end else if (bus.write_enable == 1'b1 && in_range) begin
            mem[bus.address] <= bus.write_data;
        end
    end

    // No write-through: a same-cycle read returns the pre-edge contents.
    assign bus.read_data = in_range ? mem[bus.address] : '0;
endmodule

// File: tb/tb_data_memory.sv
// Directed bench for data_memory: reset clear, write/read, hold, aliasing, same-cycle
// ordering, asynchronous reset, and the short-array out-of-range behaviour.
module tb_data_memory;
    logic clk   = 1'b0;
    logic rst_n = 1'b1;
    int   n_checks = 0;
    int   n_fail   = 0;

    data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) bus ();
    data_memory_if #(.DATA_WIDTH(32), .ADDR_WIDTH(8)) sbus ();

    data_memory dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    data_memory #(.DEPTH(200)) sdut (.clk(clk), .rst_n(rst_n), .bus(sbus.slave));

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic rd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        bus.address = a;
        #1;
        check(tag, bus.read_data, exp);
    endtask

    task automatic srd(input string tag, input logic [7:0] a, input logic [31:0] exp);
        sbus.address = a;
        #1;
        check(tag, sbus.read_data, exp);
    endtask

    initial begin
        bus.address = '0;  bus.write_data = '0;  bus.write_enable = 1'b0;
        sbus.address = '0; sbus.write_data = '0; sbus.write_enable = 1'b0;

        // 1: reset then sweep
        #2 rst_n = 1'b0;
        #10 rst_n = 1'b1;
        rd("reset_00", 8'h00, 32'h0);
        rd("reset_7f", 8'h7F, 32'h0);
        rd("reset_ff", 8'hFF, 32'h0);

        // 2: single write
        @(negedge clk);
        bus.address = 8'h00; bus.write_data = 32'hAABBCCDD; bus.write_enable = 1'b1;
        @(posedge clk); #1;
        bus.write_enable = 1'b0;
        rd("write_00", 8'h00, 32'hAABBCCDD);

        // 3: write_enable low holds contents
        bus.write_data = 32'h12345678;
        repeat (3) @(posedge clk);
        #1;
        rd("hold_00", 8'h00, 32'hAABBCCDD);

        // 4: consecutive writes, aliasing and top address
        @(negedge clk);
        bus.address = 8'h01; bus.write_data = 32'h11111111; bus.write_enable = 1'b1;
        @(negedge clk);
        bus.address = 8'hFF; bus.write_data = 32'hFFFFFFFF;
        @(negedge clk);
        bus.write_enable = 1'b0;
        rd("alias_00", 8'h00, 32'hAABBCCDD);
        rd("alias_01", 8'h01, 32'h11111111);
        rd("alias_ff", 8'hFF, 32'hFFFFFFFF);
        rd("alias_7f", 8'h7F, 32'h0);

        // 5: same-cycle write and read
        @(negedge clk);
        bus.address = 8'h01; bus.write_data = 32'hCAFEF00D; bus.write_enable = 1'b1;
        #1;
        check("same_before", bus.read_data, 32'h11111111);
        @(posedge clk); #1;
        check("same_after", bus.read_data, 32'hCAFEF00D);
        bus.write_enable = 1'b0;

        // short array: last word works, out-of-range writes dropped and read as 0
        @(negedge clk);
        sbus.address = 8'd199; sbus.write_data = 32'h5A5A5A5A; sbus.write_enable = 1'b1;
        @(negedge clk);
        sbus.address = 8'd200; sbus.write_data = 32'hDEADBEEF;
        @(negedge clk);
        sbus.write_enable = 1'b0;
        srd("short_199", 8'd199, 32'h5A5A5A5A);
        srd("short_200", 8'd200, 32'h0);
        srd("short_255", 8'd255, 32'h0);
        rd("big_c8", 8'hC8, 32'h0);

        // 6: asynchronous reset between edges with write_enable high
        @(negedge clk);
        bus.address = 8'h01; bus.write_data = 32'h77777777; bus.write_enable = 1'b1;
        #2 rst_n = 1'b0;
        #1;
        check("async_rst_01", bus.read_data, 32'h0);
        rd("async_rst_00", 8'h00, 32'h0);
        srd("async_rst_s199", 8'd199, 32'h0);
        bus.address = 8'h01;
        @(posedge clk); #1;
        check("write_in_reset", bus.read_data, 32'h0);
        @(negedge clk);
        rst_n = 1'b1; bus.write_enable = 1'b0;
        rd("post_rst_00", 8'h00, 32'h0);
        rd("post_rst_01", 8'h01, 32'h0);
        rd("post_rst_ff", 8'hFF, 32'h0);

        // first write after release is honoured
        @(negedge clk);
        bus.address = 8'h02; bus.write_data = 32'h13579BDF; bus.write_enable = 1'b1;
        @(posedge clk); #1;
        bus.write_enable = 1'b0;
        rd("first_after_rst", 8'h02, 32'h13579BDF);
        rd("neighbor_03", 8'h03, 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
